s2mm_ring_cmd_sched: RTL and testbench
======================================

Name: s2mm_ring_cmd_sched

Overview:
Command scheduler for the S2MM datamover write path. Splits a capture buffer into fixed-size chunks and issues one 72-bit datamover command per chunk, either single-shot or as a continuous ring with wrap-around. Bounds the number of in-flight commands, checks the returned status stream in order, and reports progress and errors to the register block. Sits between the register block and the datamover command/status ports, in the datamover command clock domain.

Parameters:
CHUNK_BYTES, 4096, bytes per command (BTT); power of two, at most 2^23-1.
MAX_OUTSTANDING, 4, maximum commands issued without a returned status, 1..15.
ADDR_W, 32, address width.

Ports:
clk  in  1  command/status clock.
rst  in  1  asynchronous, active-high reset.
start  in  1  pulse; latches configuration and begins the run.
stop  in  1  pulse; ends a continuous run cleanly.
soft_reset  in  1  synchronous abort to IDLE; clears all counters.
continuous  in  1  1 = ring mode, 0 = single pass.
base_addr  in  ADDR_W  buffer start address.
buf_size  in  32  buffer size in bytes.
cmd_tdata  out  72  datamover command.
cmd_tvalid  out  1  command valid.
cmd_tready  in  1  command ready.
sts_tdata  in  8  datamover status {OKAY, SLVERR, DECERR, INTERR, TAG[3:0]}.
sts_tvalid  in  1  status valid.
sts_tready  out  1  constant 1.
busy  out  1  state is not IDLE, DONE or ERROR.
done  out  1  level; single pass or stopped run complete.
err  out  1  level; in ERROR state.
cfg_err  out  1  sticky; bad configuration at start.
err_status  out  8  first failing status word, or expected tag on a tag mismatch.
cur_addr  out  ADDR_W  address of the last accepted command.
wrap_count  out  8  ring wraps; wraps modulo 256.
outstanding  out  4  in-flight command count.

Behaviour:
- Reset (rst or soft_reset): state IDLE; cmd_tvalid, done, err, cfg_err = 0; err_status, cur_addr, wrap_count, outstanding = 0; tag counter = 0.
- Command format: [22:0] = CHUNK_BYTES, [23] = 1 (INCR), [29:24] = 0, [30] = 1 (EOF), [31] = 0, [63:32] = address, [67:64] = tag, [71:68] = 0.
- start is accepted in IDLE or DONE only and ignored otherwise. base_addr, buf_size and continuous are latched on start.
- On start, cfg_err is set and the block stays idle if buf_size == 0, buf_size is not a multiple of CHUNK_BYTES, or base_addr is not CHUNK_BYTES-aligned. Otherwise done and cfg_err clear and the state moves to ISSUE.
- States:
  - IDLE
  - ISSUE: cmd_tvalid=1 when outstanding < MAX_OUTSTANDING. Entering ISSUE from start gives cmd_tvalid on the next cycle (1-cycle latency).
  - DRAIN: no new commands; wait for outstanding == 0.
  - DONE
  - ERROR
- AXIS rule: once cmd_tvalid is asserted, cmd_tdata is held and tvalid stays high until the handshake, even if stop arrives. Only rst or soft_reset may drop it.
- On a command handshake:
  - cur_addr takes the address; the tag increments modulo 16.
  - The next address is addr + CHUNK_BYTES. If that reaches base + buf_size, the address wraps to base and wrap_count increments.
  - Single pass: after the last chunk, go to DRAIN.
  - Continuous: stay in ISSUE.
- outstanding: +1 on a command handshake, -1 on a status handshake, unchanged when both happen in the same cycle. It never underflows; a status received with outstanding == 0 is an error.
- Status check, in order: the expected tag is (tag of the oldest outstanding command). Error if OKAY == 0, any of bits [6:4] is set, or the tag is not the expected tag.
- On error: go to ERROR, set err, latch err_status (first error only), stop issuing. An already-asserted command completes its handshake before issuing stops. ERROR exits only via rst or soft_reset.
- stop in ISSUE (continuous or single pass): after any pending handshake, go to DRAIN. stop in other states is ignored.
- When DRAIN reaches outstanding == 0, go to DONE and set done.
- Simultaneous start and soft_reset: soft_reset wins.

Decomposition:
- Package s2mm_pkg: datamover command field offsets, status bit positions, state enum typedef, command struct typedef.
- One sub-module, s2mm_sts_checker: expected-tag counter, outstanding counter and error decode.

Test Plan:
- base=0x1000_0000, size=0x4000, single pass, cmd_tready=1, status OKAY returned 3 cycles after each command → 4 commands at 0x1000_0000/1000/2000/3000, BTT=0x1000, tags 0..3, then done=1 and outstanding=0.
- Continuous, size=0x2000, stop after 5 commands → addresses alternate 0x1000_0000/0x1000_1000, wrap_count=2 after the 4th accept and wraps as expected, DRAIN, then done.
- sts_tvalid held low, cmd_tready=1 → exactly MAX_OUTSTANDING=4 commands issued, then cmd_tvalid=0 until a status returns.
- cmd_tready=0 with stop pulsed → tvalid and tdata held stable until tready, then no further commands.
- Status 0xC1 (OKAY+SLVERR) on tag 1 → err=1, err_status=0xC1, no new commands; soft_reset returns to IDLE with all outputs 0.
- buf_size=0x1800 → cfg_err=1, no command issued; rst asserted mid-run → all outputs cleared asynchronously.

Source files
------------

// File: rtl/s2mm_pkg.sv
// Shared definitions for the S2MM ring command scheduler:
// datamover command layout, status bits and scheduler states.
package s2mm_pkg;

  localparam int BTT_LSB  = 0;
  localparam int BTT_W    = 23;
  localparam int INCR_BIT = 23;
  localparam int EOF_BIT  = 30;
  localparam int ADDR_LSB = 32;
  localparam int TAG_LSB  = 64;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_INTERR = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  typedef struct packed {
    logic [3:0]  rsvd;
    logic [3:0]  tag;
    logic [31:0] addr;
    logic        dre;
    logic        eof;
    logic [5:0]  drr;
    logic        incr;
    logic [22:0] btt;
  } dm_cmd_t;

  function automatic dm_cmd_t mk_cmd(
    input logic [31:0] addr,
    input logic [3:0]  tag,
    input logic [22:0] btt
  );
    logic [71:0] c;
    c = '0;
    c[BTT_LSB +: BTT_W] = btt;
    c[INCR_BIT]         = 1'b1;
    c[EOF_BIT]          = 1'b1;
    c[ADDR_LSB +: 32]   = addr;
    c[TAG_LSB +: 4]     = tag;
    return dm_cmd_t'(c);
  endfunction

endpackage

// File: rtl/s2mm_ring_cmd_sched_sts_checker.sv
// In-order status checker: tracks the expected tag and the
// number of in-flight commands, and flags bad status words.
module s2mm_sts_checker
  import s2mm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       cmd_hs,
  input  logic       sts_valid,
  input  logic [7:0] sts_data,
  output logic [3:0] outst_o,
  output logic [3:0] outst_nxt_o,
  output logic       err_o,
  output logic [7:0] err_word_o
);

  logic [3:0] exp_tag_q, exp_tag_d;
  logic [3:0] outst_q, outst_d;
  logic       orphan;
  logic       sts_take;

  // A status with nothing in flight cannot be matched to a command
  assign orphan   = sts_valid && (outst_q == 4'd0) && !cmd_hs;
  assign sts_take = sts_valid && !orphan;

  always_comb begin
    exp_tag_d  = exp_tag_q;
    outst_d    = outst_q;
    err_o      = 1'b0;
    err_word_o = sts_data;
    if (orphan) begin
      err_o = 1'b1;
    end else if (sts_take) begin
      exp_tag_d = exp_tag_q + 4'd1;
      if (!sts_data[STS_OKAY] ||
          |sts_data[STS_SLVERR:STS_INTERR]) begin
        err_o = 1'b1;
      end else if (sts_data[3:0] != exp_tag_q) begin
        err_o      = 1'b1;
        err_word_o = {4'h0, exp_tag_q};
      end
    end
    case ({cmd_hs, sts_take})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_tag_q <= '0;
      outst_q   <= '0;
    end else if (clr) begin
      exp_tag_q <= '0;
      outst_q   <= '0;
    end else begin
      exp_tag_q <= exp_tag_d;
      outst_q   <= outst_d;
    end
  end

  assign outst_o     = outst_q;
  assign outst_nxt_o = outst_d;

endmodule

// File: rtl/s2mm_ring_cmd_sched.sv
// S2MM datamover command scheduler: chunks a capture buffer into
// fixed-size commands, single pass or as a wrapping ring.
module s2mm_ring_cmd_sched
  import s2mm_pkg::*;
#(
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              soft_reset,
  input  logic              continuous,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       buf_size,
  output logic [71:0]       cmd_tdata,
  output logic              cmd_tvalid,
  input  logic              cmd_tready,
  input  logic [7:0]        sts_tdata,
  input  logic              sts_tvalid,
  output logic              sts_tready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cfg_err,
  output logic [7:0]        err_status,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [7:0]        wrap_count,
  output logic [3:0]        outstanding
);

  localparam int XW = (ADDR_W > 32 ? ADDR_W : 32) + 1;
  localparam logic [31:0]       SMASK = 32'(CHUNK_BYTES - 1);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'(CHUNK_BYTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       size_q, size_d;
  logic              cont_q, cont_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        wrap_q, wrap_d;
  logic [3:0]        tag_q, tag_d;
  logic              tvalid_q, tvalid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cfg_err_q, cfg_err_d;
  logic [7:0]        err_status_q, err_status_d;
  logic              stop_pend_q, stop_pend_d;

  logic          cmd_hs;
  logic          cfg_bad;
  logic [XW-1:0] nxt_addr;
  logic [XW-1:0] end_addr;
  logic          wrap_now;
  logic          last_hs;
  logic          stop_req;
  logic          can_issue;
  logic          sts_err;
  logic [7:0]    sts_word;
  logic [3:0]    outst;
  logic [3:0]    outst_nxt;
  dm_cmd_t       cmd;

  s2mm_sts_checker u_chk (
    .clk         (clk),
    .rst         (rst),
    .clr         (soft_reset),
    .cmd_hs      (cmd_hs),
    .sts_valid   (sts_tvalid),
    .sts_data    (sts_tdata),
    .outst_o     (outst),
    .outst_nxt_o (outst_nxt),
    .err_o       (sts_err),
    .err_word_o  (sts_word)
  );

  assign cmd_hs    = tvalid_q & cmd_tready;
  assign cfg_bad   = (buf_size == 32'd0) ||
                     |(buf_size & SMASK) ||
                     |(base_addr & AMASK);
  assign nxt_addr  = XW'(addr_q) + XW'(CHUNK_BYTES);
  assign end_addr  = XW'(base_q) + XW'(size_q);
  assign wrap_now  = nxt_addr >= end_addr;
  assign last_hs   = cmd_hs && wrap_now && !cont_q;
  assign stop_req  = stop | stop_pend_q;
  assign can_issue = outst_nxt < 4'(MAX_OUTSTANDING);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    cont_d       = cont_q;
    addr_d       = addr_q;
    cur_addr_d   = cur_addr_q;
    wrap_d       = wrap_q;
    tag_d        = tag_q;
    tvalid_d     = tvalid_q & ~cmd_hs;
    done_d       = done_q;
    err_d        = err_q;
    cfg_err_d    = cfg_err_q;
    err_status_d = err_status_q;
    stop_pend_d  = stop_pend_q;
    if (cmd_hs) begin
      cur_addr_d = addr_q;
      tag_d      = tag_q + 4'd1;
      addr_d     = wrap_now ? base_q : ADDR_W'(nxt_addr);
      if (wrap_now) wrap_d = wrap_q + 8'd1;
    end
    if (sts_err) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      if (!err_q) err_status_d = sts_word;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_d = base_addr;
            size_d = buf_size;
            cont_d = continuous;
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              cfg_err_d   = 1'b0;
              done_d      = 1'b0;
              wrap_d      = '0;
              stop_pend_d = 1'b0;
              addr_d      = base_addr;
              state_d     = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // A pending command must handshake before we stop issuing
          if (last_hs || (stop_req && (!tvalid_q || cmd_hs))) begin
            state_d = S_DRAIN;
          end else begin
            stop_pend_d = stop_req;
            if ((!tvalid_q || cmd_hs) && can_issue) tvalid_d = 1'b1;
          end
        end
        S_DRAIN: begin
          if (outst == 4'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_ERROR: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      cont_q       <= 1'b0;
      addr_q       <= '0;
      cur_addr_q   <= '0;
      wrap_q       <= '0;
      tag_q        <= '0;
      tvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
      err_status_q <= '0;
      stop_pend_q  <= 1'b0;
    end else if (soft_reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      cont_q       <= 1'b0;
      addr_q       <= '0;
      cur_addr_q   <= '0;
      wrap_q       <= '0;
      tag_q        <= '0;
      tvalid_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
      err_status_q <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      size_q       <= size_d;
      cont_q       <= cont_d;
      addr_q       <= addr_d;
      cur_addr_q   <= cur_addr_d;
      wrap_q       <= wrap_d;
      tag_q        <= tag_d;
      tvalid_q     <= tvalid_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cfg_err_q    <= cfg_err_d;
      err_status_q <= err_status_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign cmd        = mk_cmd(32'(addr_q), tag_q, 23'(CHUNK_BYTES));
  assign cmd_tdata  = cmd;
  assign cmd_tvalid = tvalid_q;
  assign sts_tready = 1'b1;
  assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done       = done_q;
  assign err        = err_q;
  assign cfg_err    = cfg_err_q;
  assign err_status = err_status_q;
  assign cur_addr   = cur_addr_q;
  assign wrap_count = wrap_q;
  assign outstanding = outst;

endmodule

// File: tb/tb_s2mm_ring_cmd_sched.sv
// Testbench for s2mm_ring_cmd_sched: directed scenarios plus
// randomized runs checked against an arithmetic command model.
module tb_s2mm_ring_cmd_sched;

  localparam int CHUNK = 4096;
  localparam int MAXO  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, soft_reset, continuous;
  logic [31:0] base_addr, buf_size;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid, cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid, sts_tready;
  logic        busy, done, err, cfg_err;
  logic [7:0]  err_status;
  logic [31:0] cur_addr;
  logic [7:0]  wrap_count;
  logic [3:0]  outstanding;

  always #5 clk = ~clk;

  s2mm_ring_cmd_sched #(
    .CHUNK_BYTES(CHUNK), .MAX_OUTSTANDING(MAXO), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .soft_reset(soft_reset), .continuous(continuous),
    .base_addr(base_addr), .buf_size(buf_size),
    .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready), .sts_tdata(sts_tdata),
    .sts_tvalid(sts_tvalid), .sts_tready(sts_tready),
    .busy(busy), .done(done), .err(err), .cfg_err(cfg_err),
    .err_status(err_status), .cur_addr(cur_addr),
    .wrap_count(wrap_count), .outstanding(outstanding)
  );

  typedef struct {
    int         due;
    logic [3:0] tag;
  } pend_t;

  int          total  = 0;
  int          passed = 0;
  logic [71:0] acc[$];
  pend_t       pend[$];
  int          cyc     = 0;
  int          tr_mode = 1;
  bit          sts_en  = 1'b1;
  int          lat_min = 3;
  int          lat_max = 3;
  bit          inj     = 1'b0;
  logic [3:0]  inj_tag = 4'd0;
  bit          flush   = 1'b0;
  int          ntag    = 0;

  // Datamover stand-in: drives tready/status, records accepted commands
  initial begin
    cmd_tready = 1'b0;
    sts_tvalid = 1'b0;
    sts_tdata  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (flush) begin
        pend.delete();
        sts_tvalid = 1'b0;
      end else begin
        case (tr_mode)
          0:       cmd_tready = 1'b0;
          1:       cmd_tready = 1'b1;
          default: cmd_tready = 1'($urandom_range(0, 1));
        endcase
        sts_tvalid = 1'b0;
        if (sts_en && pend.size() > 0 && pend[0].due <= cyc) begin
          sts_tvalid = 1'b1;
          sts_tdata  = {4'h8, pend[0].tag};
          if (inj && pend[0].tag == inj_tag) begin
            sts_tdata = {4'hC, pend[0].tag};
            inj = 1'b0;
          end
          void'(pend.pop_front());
        end
        if (cmd_tvalid && cmd_tready && !rst) begin
          acc.push_back(cmd_tdata);
          pend.push_back('{due: cyc + int'($urandom_range(lat_min, lat_max)),
                           tag: cmd_tdata[67:64]});
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] a,
                                          input logic [3:0] t);
    return {4'h0, t, a, 1'b0, 1'b1, 6'h00, 1'b1, 23'(CHUNK)};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {cmd_tvalid, busy, done, err, cfg_err, err_status,
             cur_addr, wrap_count, outstanding}, '0);
  endtask

  task automatic do_soft_reset();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    ntag = 0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] s,
                          input logic c);
    base_addr  = b;
    buf_size   = s;
    continuous = c;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 600 && !done; i++) step();
    chk({nm, "_done"}, done, 1);
  endtask

  task automatic wait_acc(input string nm, input int k0, input int n);
    for (int i = 0; i < 600 && (acc.size() - k0) < n; i++) step();
    chk({nm, "_acc_to"}, (acc.size() - k0) >= n, 1);
  endtask

  task automatic run_check(input string nm, input int k0,
                           input logic [31:0] b, input int nch);
    int n;
    n = acc.size() - k0;
    for (int k = 0; k < n; k++)
      chk(nm, acc[k0 + k],
          exp_cmd(b + 32'((k % nch) * CHUNK), 4'((ntag + k) % 16)));
    ntag += n;
  endtask

  function automatic logic [31:0] rnd_base();
    return 32'($urandom_range(0, 32'hEFFFF)) << 12;
  endfunction

  initial begin
    int          k0, n, n1, nch, m;
    logic [31:0] b;
    logic [71:0] held;
    bit          stable;

    rst = 1'b1; start = 1'b0; stop = 1'b0; soft_reset = 1'b0;
    continuous = 1'b0; base_addr = '0; buf_size = '0;
    step(3);
    chk_zero("reset_outs");
    chk("sts_tready", sts_tready, 1);
    rst = 1'b0;
    step(2);

    // single pass, 4 chunks, status 3 cycles later
    k0 = acc.size();
    do_start(32'h1000_0000, 32'h4000, 1'b0);
    chk("sp_busy", busy, 1);
    wait_done("sp");
    chk("sp_n", acc.size() - k0, 4);
    run_check("sp_cmd", k0, 32'h1000_0000, 4);
    chk("sp_cur", cur_addr, 32'h1000_3000);
    chk("sp_wrap", wrap_count, 1);
    chk("sp_outst", outstanding, 0);
    chk("sp_idle", busy, 0);

    // continuous ring of 2 chunks, stop after 5 commands
    do_soft_reset();
    tr_mode = 2; lat_min = 1; lat_max = 5;
    k0 = acc.size();
    do_start(32'h1000_0000, 32'h2000, 1'b1);
    wait_acc("ring", k0, 5);
    do_stop();
    wait_done("ring");
    chk("ring_n", acc.size() - k0, 5);
    run_check("ring_cmd", k0, 32'h1000_0000, 2);
    chk("ring_wrap", wrap_count, 2);
    chk("ring_cur", cur_addr, 32'h1000_0000);

    // no status returned: issue stops at MAX_OUTSTANDING
    do_soft_reset();
    tr_mode = 1; sts_en = 1'b0; lat_min = 2; lat_max = 2;
    b = rnd_base();
    k0 = acc.size();
    do_start(b, 32'h8000, 1'b1);
    step(30);
    chk("max_n", acc.size() - k0, MAXO);
    chk("max_tvalid", cmd_tvalid, 0);
    chk("max_outst", outstanding, MAXO);
    chk("max_busy", busy, 1);
    sts_en = 1'b1;
    wait_acc("max_resume", k0, MAXO + 1);
    do_stop();
    wait_done("max");
    run_check("max_cmd", k0, b, 8);

    // backpressure with stop: command held until accepted
    do_soft_reset();
    tr_mode = 0;
    b = rnd_base();
    k0 = acc.size();
    do_start(b, 32'h4000, 1'b0);
    for (int i = 0; i < 20 && !cmd_tvalid; i++) step();
    chk("bp_tvalid", cmd_tvalid, 1);
    held = cmd_tdata;
    do_stop();
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!cmd_tvalid || cmd_tdata !== held) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    tr_mode = 1;
    wait_done("bp");
    chk("bp_n", acc.size() - k0, 1);
    run_check("bp_cmd", k0, b, 4);
    chk("bp_tvalid_end", cmd_tvalid, 0);

    // SLVERR on tag 1
    do_soft_reset();
    tr_mode = 1; lat_min = 2; lat_max = 4;
    inj = 1'b1; inj_tag = 4'd1;
    k0 = acc.size();
    do_start(32'h2000_0000, 32'h3000, 1'b1);
    for (int i = 0; i < 200 && !err; i++) step();
    chk("err_flag", err, 1);
    chk("err_status", err_status, 8'hC1);
    chk("err_busy", busy, 0);
    step(10);
    n1 = acc.size();
    step(10);
    chk("err_no_issue", acc.size(), n1);
    chk("err_tvalid", cmd_tvalid, 0);
    for (int i = 0; i < 100 && pend.size() != 0; i++) step();
    step(2);
    chk("err_outst", outstanding, 0);
    run_check("err_cmd", k0, 32'h2000_0000, 3);
    do_soft_reset();
    step();
    chk_zero("err_softrst");

    // randomized runs, back to back from DONE
    for (int r = 0; r < 4; r++) begin
      tr_mode = 2;
      lat_min = 1;
      lat_max = 6;
      nch = int'($urandom_range(1, 5));
      b = rnd_base();
      k0 = acc.size();
      do_start(b, 32'(nch * CHUNK), 1'(r % 2));
      if (r % 2 == 1) begin
        m = 2 * nch + 1;
        wait_acc("rnd", k0, m);
        do_stop();
      end else begin
        m = nch;
      end
      wait_done("rnd");
      n = acc.size() - k0;
      chk("rnd_n", n, m);
      chk("rnd_wrap", wrap_count, (n / nch) % 256);
      run_check("rnd_cmd", k0, b, nch);
    end

    // bad configurations
    do_soft_reset();
    tr_mode = 1; lat_min = 2; lat_max = 3;
    for (int i = 0; i < 3; i++) begin
      k0 = acc.size();
      case (i)
        0:       do_start(32'h1000_0000, 32'h1800, 1'b0);
        1:       do_start(32'h1000_0000, 32'h0, 1'b0);
        default: do_start(32'h1000_0800, 32'h2000, 1'b0);
      endcase
      step(10);
      chk("cfg_err", cfg_err, 1);
      chk("cfg_idle", {busy, cmd_tvalid}, 0);
      chk("cfg_no_cmd", acc.size() - k0, 0);
    end
    k0 = acc.size();
    do_start(32'h3000_0000, 32'h8000, 1'b0);
    chk("cfg_clear", {cfg_err, busy}, 2'b01);
    wait_acc("arst", k0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    flush = 1'b1;
    step(2);
    flush = 1'b0;
    rst = 1'b0;
    step(2);
    chk_zero("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
